// File: rtl/riscv_v_wb_pipe.sv
// Vector EXE->MEM->WB result pipe: builds per-byte write enables from vl/osize/mask and stages them with stall/flush.
// Optional macro RISCV_V_WB_PERF_CNT_EN adds WB write instruction/byte counters.
module riscv_v_wb_pipe #(
    parameter int DATA_WIDTH = 128,
    parameter int NUM_BYTES  = DATA_WIDTH / 8,
    parameter int ADDR_WIDTH = 5,
    parameter int NUM_OSIZES = 4,
    parameter int VL_WIDTH   = $clog2(NUM_BYTES) + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  exe_valid,
    input  logic                  exe_wr_en,
    input  logic [ADDR_WIDTH-1:0] exe_rd_addr,
    input  logic [DATA_WIDTH-1:0] exe_data,
    input  logic [NUM_OSIZES-1:0] exe_osize_vector,
    input  logic [VL_WIDTH-1:0]   exe_vl,
    input  logic                  exe_masked,
    input  logic [NUM_BYTES-1:0]  exe_mask,
    input  logic                  stall,
    input  logic                  flush,
    output logic [NUM_BYTES-1:0]  rf_wr_en_mem,
    output logic [ADDR_WIDTH-1:0] rf_wr_addr_mem,
    output logic [DATA_WIDTH-1:0] rf_wr_data_mem,
    output logic [NUM_BYTES-1:0]  rf_wr_en_wb,
    output logic [ADDR_WIDTH-1:0] rf_wr_addr_wb,
    output logic [DATA_WIDTH-1:0] rf_wr_data_wb
`ifdef RISCV_V_WB_PERF_CNT_EN
    ,
    output logic [31:0]           wb_instr_cnt,
    output logic [31:0]           wb_byte_cnt
`endif
);

    logic [NUM_BYTES-1:0]  exe_byte_en;
    logic [NUM_BYTES-1:0]  en_mem_d, en_mem_q, en_wb_d, en_wb_q;
    logic [ADDR_WIDTH-1:0] addr_mem_d, addr_mem_q, addr_wb_d, addr_wb_q;
    logic [DATA_WIDTH-1:0] data_mem_d, data_mem_q, data_wb_d, data_wb_q;

    // Byte j belongs to element j>>k; since that index is always below NUM_BYTES/B,
    // comparing against vl directly is the same as comparing against min(vl, NUM_BYTES/B).
    always_comb begin
        exe_byte_en = '0;
        if (exe_valid && exe_wr_en && $onehot(exe_osize_vector)) begin
            for (int k = 0; k < NUM_OSIZES; k++) begin
                if (exe_osize_vector[k]) begin
                    for (int j = 0; j < NUM_BYTES; j++) begin
                        if (((j >> k) < int'(exe_vl)) && (!exe_masked || exe_mask[j >> k]))
                            exe_byte_en[j] = 1'b1;
                    end
                end
            end
        end
    end

    always_comb begin
        en_mem_d   = en_mem_q;
        addr_mem_d = addr_mem_q;
        data_mem_d = data_mem_q;
        if (!stall) begin
            en_mem_d   = flush ? '0 : exe_byte_en;
            addr_mem_d = exe_rd_addr;
            data_mem_d = exe_data;
        end
        // A stalled MEM entry must not write WB until the stall lifts, so WB gets a bubble.
        en_wb_d   = stall ? '0 : en_mem_q;
        addr_wb_d = addr_mem_q;
        data_wb_d = data_mem_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            en_mem_q   <= '0;
            addr_mem_q <= '0;
            data_mem_q <= '0;
            en_wb_q    <= '0;
            addr_wb_q  <= '0;
            data_wb_q  <= '0;
        end else begin
            en_mem_q   <= en_mem_d;
            addr_mem_q <= addr_mem_d;
            data_mem_q <= data_mem_d;
            en_wb_q    <= en_wb_d;
            addr_wb_q  <= addr_wb_d;
            data_wb_q  <= data_wb_d;
        end
    end

    assign rf_wr_en_mem   = en_mem_q;
    assign rf_wr_addr_mem = addr_mem_q;
    assign rf_wr_data_mem = data_mem_q;
    assign rf_wr_en_wb    = en_wb_q;
    assign rf_wr_addr_wb  = addr_wb_q;
    assign rf_wr_data_wb  = data_wb_q;

`ifdef RISCV_V_WB_PERF_CNT_EN
    logic [31:0] instr_cnt_d, instr_cnt_q, byte_cnt_d, byte_cnt_q;

    always_comb begin
        instr_cnt_d = instr_cnt_q;
        byte_cnt_d  = byte_cnt_q;
        if (|en_wb_q) begin
            instr_cnt_d = instr_cnt_q + 32'd1;
            byte_cnt_d  = byte_cnt_q + 32'($countones(en_wb_q));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instr_cnt_q <= '0;
            byte_cnt_q  <= '0;
        end else begin
            instr_cnt_q <= instr_cnt_d;
            byte_cnt_q  <= byte_cnt_d;
        end
    end

    assign wb_instr_cnt = instr_cnt_q;
    assign wb_byte_cnt  = byte_cnt_q;
`endif

endmodule

// File: tb/tb_riscv_v_wb_pipe.sv
// Directed bench for riscv_v_wb_pipe: enable-generation table plus stall, flush and reset sequences.
module tb_riscv_v_wb_pipe;

    logic         clk = 1'b0;
    logic         rst;
    logic         exe_valid, exe_wr_en, exe_masked, stall, flush;
    logic [4:0]   exe_rd_addr, exe_vl;
    logic [127:0] exe_data;
    logic [3:0]   exe_osize_vector;
    logic [15:0]  exe_mask;
    logic [15:0]  rf_wr_en_mem, rf_wr_en_wb;
    logic [4:0]   rf_wr_addr_mem, rf_wr_addr_wb;
    logic [127:0] rf_wr_data_mem, rf_wr_data_wb;
`ifdef RISCV_V_WB_PERF_CNT_EN
    logic [31:0]  wb_instr_cnt, wb_byte_cnt;
`endif

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    riscv_v_wb_pipe dut (
        .clk(clk), .rst(rst),
        .exe_valid(exe_valid), .exe_wr_en(exe_wr_en), .exe_rd_addr(exe_rd_addr),
        .exe_data(exe_data), .exe_osize_vector(exe_osize_vector), .exe_vl(exe_vl),
        .exe_masked(exe_masked), .exe_mask(exe_mask), .stall(stall), .flush(flush),
        .rf_wr_en_mem(rf_wr_en_mem), .rf_wr_addr_mem(rf_wr_addr_mem), .rf_wr_data_mem(rf_wr_data_mem),
        .rf_wr_en_wb(rf_wr_en_wb), .rf_wr_addr_wb(rf_wr_addr_wb), .rf_wr_data_wb(rf_wr_data_wb)
`ifdef RISCV_V_WB_PERF_CNT_EN
        , .wb_instr_cnt(wb_instr_cnt), .wb_byte_cnt(wb_byte_cnt)
`endif
    );

    typedef struct {
        logic         valid;
        logic         wr;
        logic [4:0]   rd;
        logic [127:0] data;
        logic [3:0]   osz;
        logic [4:0]   vl;
        logic         masked;
        logic [15:0]  mask;
        logic [15:0]  exp_en;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        exe_valid        = v.valid;
        exe_wr_en        = v.wr;
        exe_rd_addr      = v.rd;
        exe_data         = v.data;
        exe_osize_vector = v.osz;
        exe_vl           = v.vl;
        exe_masked       = v.masked;
        exe_mask         = v.mask;
    endtask

    task automatic idle();
        exe_valid = 1'b0;
        exe_wr_en = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(logic valid, logic wr, logic [4:0] rd, logic [127:0] data,
                                logic [3:0] osz, logic [4:0] vl, logic masked,
                                logic [15:0] mask, logic [15:0] exp_en);
        vec_t v;
        v.valid = valid; v.wr = wr; v.rd = rd; v.data = data; v.osz = osz;
        v.vl = vl; v.masked = masked; v.mask = mask; v.exp_en = exp_en;
        return v;
    endfunction

    initial begin
        vecs[0]  = mk(1, 1, 5'd3,  128'h0F0E0D0C0B0A09080706050403020100, 4'b0100, 5'd4,  0, 16'h0000, 16'hFFFF);
        vecs[1]  = mk(1, 1, 5'd7,  128'h11111111111111111111111111111111, 4'b0010, 5'd3,  1, 16'h0005, 16'h0033);
        vecs[2]  = mk(1, 1, 5'd8,  128'h22222222222222222222222222222222, 4'b0001, 5'd20, 0, 16'h0000, 16'hFFFF);
        vecs[3]  = mk(1, 1, 5'd9,  128'h33333333333333333333333333333333, 4'b1000, 5'd1,  0, 16'h0000, 16'h00FF);
        vecs[4]  = mk(1, 1, 5'd10, 128'h44444444444444444444444444444444, 4'b0001, 5'd0,  0, 16'h0000, 16'h0000);
        vecs[5]  = mk(1, 1, 5'd11, 128'h55555555555555555555555555555555, 4'b0011, 5'd16, 0, 16'h0000, 16'h0000);
        vecs[6]  = mk(1, 1, 5'd12, 128'h66666666666666666666666666666666, 4'b0000, 5'd16, 0, 16'h0000, 16'h0000);
        vecs[7]  = mk(0, 1, 5'd13, 128'h77777777777777777777777777777777, 4'b0001, 5'd16, 0, 16'h0000, 16'h0000);
        vecs[8]  = mk(1, 0, 5'd14, 128'h88888888888888888888888888888888, 4'b0001, 5'd16, 0, 16'h0000, 16'h0000);
        vecs[9]  = mk(1, 1, 5'd15, 128'h99999999999999999999999999999999, 4'b0001, 5'd5,  1, 16'hFFEA, 16'h000A);
        vecs[10] = mk(1, 1, 5'd16, 128'hAAAAAAAAAAAAAAAAAAAAAAAAAAAAAAAA, 4'b1000, 5'd2,  1, 16'h0002, 16'hFF00);
        vecs[11] = mk(1, 1, 5'd17, 128'hBBBBBBBBBBBBBBBBBBBBBBBBBBBBBBBB, 4'b0100, 5'd3,  0, 16'h0000, 16'h0FFF);

        rst = 1'b1; stall = 1'b0; flush = 1'b0;
        drive(vecs[0]);
        #12;
        chk("rst_en_mem",   rf_wr_en_mem,   0);
        chk("rst_addr_mem", rf_wr_addr_mem, 0);
        chk("rst_data_mem", rf_wr_data_mem, 0);
        chk("rst_en_wb",    rf_wr_en_wb,    0);
        chk("rst_addr_wb",  rf_wr_addr_wb,  0);
        chk("rst_data_wb",  rf_wr_data_wb,  0);
        idle();
        @(negedge clk);
        rst = 1'b0;
        step();

        // Back-to-back stream: MEM shows vector n while WB shows vector n-1.
        for (int n = 0; n < 12; n++) begin
            drive(vecs[n]);
            step();
            chk($sformatf("tbl%0d_en_mem", n),   rf_wr_en_mem,   vecs[n].exp_en);
            chk($sformatf("tbl%0d_addr_mem", n), rf_wr_addr_mem, vecs[n].rd);
            chk($sformatf("tbl%0d_data_mem", n), rf_wr_data_mem, vecs[n].data);
            if (n > 0) begin
                chk($sformatf("tbl%0d_en_wb", n-1),   rf_wr_en_wb,   vecs[n-1].exp_en);
                chk($sformatf("tbl%0d_addr_wb", n-1), rf_wr_addr_wb, vecs[n-1].rd);
                chk($sformatf("tbl%0d_data_wb", n-1), rf_wr_data_wb, vecs[n-1].data);
            end
        end
        idle();
        step();
        chk("tbl11_en_wb",   rf_wr_en_wb,   vecs[11].exp_en);
        chk("tbl11_data_wb", rf_wr_data_wb, vecs[11].data);
        step();
        chk("drain_en_wb", rf_wr_en_wb, 0);

        // Stall: A held in MEM for two cycles, WB bubbles, then A writes exactly once.
        drive(mk(1, 1, 5'd1, 128'hA0A0, 4'b0001, 5'd16, 0, 16'h0, 16'hFFFF));
        step();
        chk("stl_a_en_mem", rf_wr_en_mem, 16'hFFFF);
        drive(mk(1, 1, 5'd2, 128'hB0B0, 4'b0010, 5'd3, 1, 16'h0005, 16'h0033));
        stall = 1'b1;
        for (int c = 0; c < 2; c++) begin
            step();
            chk($sformatf("stl%0d_en_mem", c),   rf_wr_en_mem,   16'hFFFF);
            chk($sformatf("stl%0d_addr_mem", c), rf_wr_addr_mem, 5'd1);
            chk($sformatf("stl%0d_en_wb", c),    rf_wr_en_wb,    0);
        end
        stall = 1'b0;
        step();
        chk("stl_a_en_wb",   rf_wr_en_wb,    16'hFFFF);
        chk("stl_a_addr_wb", rf_wr_addr_wb,  5'd1);
        chk("stl_a_data_wb", rf_wr_data_wb,  128'hA0A0);
        chk("stl_b_en_mem",  rf_wr_en_mem,   16'h0033);
        idle();
        step();
        chk("stl_b_en_wb",   rf_wr_en_wb,   16'h0033);
        chk("stl_b_addr_wb", rf_wr_addr_wb, 5'd2);

        // Flush kills the EXE instruction but the older MEM entry still retires.
        drive(mk(1, 1, 5'd4, 128'hC0C0, 4'b0001, 5'd16, 0, 16'h0, 16'hFFFF));
        step();
        drive(mk(1, 1, 5'd5, 128'hD0D0, 4'b0001, 5'd16, 0, 16'h0, 16'hFFFF));
        flush = 1'b1;
        step();
        flush = 1'b0;
        idle();
        chk("fl_en_mem",  rf_wr_en_mem,  0);
        chk("fl_en_wb",   rf_wr_en_wb,   16'hFFFF);
        chk("fl_addr_wb", rf_wr_addr_wb, 5'd4);
        step();
        chk("fl_bubble_wb", rf_wr_en_wb, 0);

        // Async reset with a full pipe during a stall.
        drive(mk(1, 1, 5'd6, 128'hE0E0, 4'b0001, 5'd16, 0, 16'h0, 16'hFFFF));
        step();
        drive(mk(1, 1, 5'd7, 128'hF0F0, 4'b0100, 5'd4, 0, 16'h0, 16'hFFFF));
        step();
        chk("full_en_mem", rf_wr_en_mem, 16'hFFFF);
        chk("full_en_wb",  rf_wr_en_wb,  16'hFFFF);
        idle();
        stall = 1'b1;
        #2 rst = 1'b1;
        #1;
        chk("arst_en_mem",   rf_wr_en_mem,   0);
        chk("arst_en_wb",    rf_wr_en_wb,    0);
        chk("arst_data_mem", rf_wr_data_mem, 0);
        chk("arst_addr_wb",  rf_wr_addr_wb,  0);
        @(negedge clk);
        rst = 1'b0;
        stall = 1'b0;
        for (int c = 0; c < 2; c++) begin
            step();
            chk($sformatf("post%0d_en_mem", c), rf_wr_en_mem, 0);
            chk($sformatf("post%0d_en_wb", c),  rf_wr_en_wb,  0);
        end

`ifdef RISCV_V_WB_PERF_CNT_EN
        // Reset just cleared counters; three issues with 16, 4 and 0 enabled bytes.
        chk("cnt_instr_rst", wb_instr_cnt, 0);
        chk("cnt_byte_rst",  wb_byte_cnt,  0);
        drive(vecs[0]);  step();
        drive(vecs[1]);  step();
        drive(vecs[4]);  step();
        idle();
        for (int c = 0; c < 3; c++) step();
        chk("cnt_instr", wb_instr_cnt, 32'd2);
        chk("cnt_byte",  wb_byte_cnt,  32'd20);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/riscv_v_wb_pipe.md
Name: riscv_v_wb_pipe

Overview:
- Vector EXE→MEM→WB result pipeline that produces the MEM- and WB-stage write data, destination address and byte write-enable vectors.
- The bypass unit forwards from these outputs, and the WB outputs drive the vector register file write port.
- Converts the EXE result's vl, osize and mask qualifiers into a per-byte write enable at EXE/MEM entry, then carries it down the pipe with stall and flush handling.

Parameters:
- DATA_WIDTH, 128, vector data width in bits.
- NUM_BYTES, DATA_WIDTH/8, number of byte lanes and bits in each wr_en vector.
- ADDR_WIDTH, 5, register file address width.
- NUM_OSIZES, 4, valid element sizes; index k = 2^k bytes (8/16/32/64 bit).
- VL_WIDTH, $clog2(NUM_BYTES)+1, width of vl.

Ports:
- clk  input  1  clock
- rst  input  1  reset
- exe_valid  input  1  EXE holds a live instruction
- exe_wr_en  input  1  instruction writes the vector RF
- exe_rd_addr  input  ADDR_WIDTH  destination register
- exe_data  input  DATA_WIDTH  EXE result
- exe_osize_vector  input  NUM_OSIZES  one-hot element size
- exe_vl  input  VL_WIDTH  active element count
- exe_masked  input  1  vm=0; apply exe_mask
- exe_mask  input  NUM_BYTES  mask bit per element index
- stall  input  1  hold MEM stage
- flush  input  1  kill the EXE instruction
- rf_wr_en_mem  output  NUM_BYTES  MEM byte enables
- rf_wr_addr_mem  output  ADDR_WIDTH  MEM destination
- rf_wr_data_mem  output  DATA_WIDTH  MEM data
- rf_wr_en_wb  output  NUM_BYTES  WB byte enables (RF write port)
- rf_wr_addr_wb  output  ADDR_WIDTH  WB destination
- rf_wr_data_wb  output  DATA_WIDTH  WB data

Behaviour:
- Reset: one clock, clk. rst is asynchronous and active-high. While rst is high, all outputs are 0.
- Enable generation (combinational, EXE side):
  - B = 2^k for the set osize bit k. Element i covers bytes i*B .. i*B+B-1, for i < NUM_BYTES/B.
  - Byte enable = exe_valid & exe_wr_en & (i < vl_eff) & (~exe_masked | exe_mask[i]).
  - vl_eff = min(exe_vl, NUM_BYTES/B).
  - exe_vl=0 gives all-zero enables.
  - An exe_osize_vector that is not one-hot gives all-zero enables. It is a protocol error; the design does not raise an alarm.
- MEM register, per cycle:
  - stall=1: hold all MEM registers. The EXE instruction is not accepted, and flush has no effect that cycle because EXE is held upstream.
  - stall=0, flush=1: load a bubble (wr_en=0). Addr and data are loaded but don't-care.
  - Otherwise: load the EXE addr, data and generated enables.
- WB register, per cycle:
  - stall=0: load the MEM contents.
  - stall=1: load a bubble (wr_en=0). The held MEM instruction writes exactly once, in the cycle after stall deasserts.
- Latency: an accepted EXE result appears on *_mem in the next cycle and on *_wb in the cycle after. Each WB write lasts exactly one cycle.
- Bubble data: data and addr registers load unconditionally when not stalled. Enables alone qualify validity.
- Back-to-back same rd_addr: MEM and WB may hold the same address with different enables. The older instruction is in WB. Forwarding priority (MEM over WB) is the consumer's concern.
- Reset mid-stall: all enables clear immediately. After release, the pipe restarts empty.

Optional Feature:
- Macro: RISCV_V_WB_PERF_CNT_EN.
- Defined:
  - Adds output wb_instr_cnt, 32 bits, and output wb_byte_cnt, 32 bits.
  - Each cycle with |rf_wr_en_wb, wb_instr_cnt increments by 1 and wb_byte_cnt adds popcount(rf_wr_en_wb).
  - Both counters wrap modulo 2^32 and reset to 0.
- Not defined: neither port nor the counter logic exists. Behaviour is otherwise identical.

Test Plan:
- osize=32-bit, vl=4, unmasked, data=0x0F..00, rd=3 → cycle+1: rf_wr_en_mem=0xFFFF, rf_wr_addr_mem=3. cycle+2: same on WB, with WB data equal to the input data.
- osize=16-bit, vl=3, masked, mask=0b101 → rf_wr_en_mem=0x0033. vl=20 at osize=8-bit → 0xFFFF (saturated).
- Issue A (rd=1), then assert stall for 2 cycles → MEM holds A for both stall cycles and WB shows 0 enables. A appears on WB once, in the first cycle after stall drops.
- flush=1 with stall=0 and a valid EXE instruction → the next MEM enables are 0x0000. The prior MEM instruction still reaches WB.
- Pipe full (MEM and WB both valid), then rst pulsed mid-cycle → all outputs 0 asynchronously. After release with no input, both stages stay 0.
- With RISCV_V_WB_PERF_CNT_EN defined: three writes with enables 0xFFFF, 0x0033 and 0x0000 → wb_instr_cnt=2, wb_byte_cnt=20.
